mac_array_sequencer: RTL and testbench

Sequences a ROWS x COLS systolic grid of MAC cells through one matrix-multiply tile. On a start request it clears the accumulators and streams k_len operand steps with per-row/per-column skew qualifiers. It then drains the wavefront and hands the results out row by row over a valid/ready port. It sits between the operand buffers / host command logic and the MAC array.

---
 rtl/mac_array_sequencer.sv | 152 +++++++++++++++
 tb/tb_mac_array_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_sequencer.sv
// Tile sequencer for a ROWS x COLS systolic MAC grid: clear, skewed operand feed,
// wavefront drain, then row-by-row result readout over a valid/ready port.
module mac_array_sequencer #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 8,
    parameter int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [K_WIDTH-1:0] k_len_i,
    input  logic               abort_i,
    input  logic               res_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               arr_clear_o,
    output logic               arr_en_o,
    output logic [K_WIDTH-1:0] op_rd_addr_o,
    output logic [ROWS-1:0]    a_row_valid_o,
    output logic [COLS-1:0]    b_col_valid_o,
    output logic               res_valid_o,
    output logic [RW-1:0]      res_row_o
);
    // Step counter is wide enough that k_len + ROWS + COLS - 2 never wraps.
    localparam int TW = K_WIDTH + $clog2(ROWS + COLS) + 1;
    localparam logic [TW-1:0] SKEW = TW'(ROWS + COLS - 2);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic [RW-1:0]      i_q, i_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [TW-1:0]      k_ext_q, k_ext_d;

    assign k_ext_q = TW'(k_q);
    assign k_ext_d = TW'(k_d);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        i_d     = i_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (k_len_i != '0)) begin
                    state_d = S_CLEAR;
                    k_d     = k_len_i;
                    t_d     = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                t_d = t_q + TW'(1);
                if (t_q == k_ext_q - TW'(1)) begin
                    state_d = (ROWS + COLS > 2) ? S_DRAIN : S_READ;
                    i_d     = '0;
                end
            end
            S_DRAIN: begin
                t_d = t_q + TW'(1);
                if (t_q == k_ext_q + SKEW - TW'(1)) begin
                    state_d = S_READ;
                    i_d     = '0;
                end
            end
            S_READ: begin
                if (res_ready_i) begin
                    if (i_q == RW'(ROWS - 1)) state_d = S_DONE;
                    else                      i_d     = i_q + RW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
                i_d     = '0;
                k_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every other transition.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            t_d     = '0;
            i_d     = '0;
            k_d     = '0;
        end
    end

    // Outputs are decoded from next state and registered, so they line up with the state.
    logic               busy_d, done_d, clear_d, en_d, rv_d, feeding_d;
    logic [K_WIDTH-1:0] addr_d;
    logic [ROWS-1:0]    av_d;
    logic [COLS-1:0]    bv_d;
    logic [RW-1:0]      row_d;

    assign feeding_d = (state_d == S_FEED) || (state_d == S_DRAIN);
    assign busy_d    = (state_d != S_IDLE);
    assign done_d    = (state_d == S_DONE);
    assign clear_d   = (state_d == S_CLEAR);
    assign en_d      = feeding_d;
    assign rv_d      = (state_d == S_READ);
    assign row_d     = (state_d == S_READ) ? i_d : '0;
    assign addr_d    = (state_d == S_FEED)  ? t_d[K_WIDTH-1:0] :
                       (state_d == S_DRAIN) ? (k_d - K_WIDTH'(1)) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_valid
            assign av_d[gi] = feeding_d && (t_d >= TW'(gi)) && ((t_d - TW'(gi)) < k_ext_d);
        end
        for (gi = 0; gi < COLS; gi++) begin : g_col_valid
            assign bv_d[gi] = feeding_d && (t_d >= TW'(gi)) && ((t_d - TW'(gi)) < k_ext_d);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            t_q           <= '0;
            i_q           <= '0;
            k_q           <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            arr_clear_o   <= 1'b0;
            arr_en_o      <= 1'b0;
            op_rd_addr_o  <= '0;
            a_row_valid_o <= '0;
            b_col_valid_o <= '0;
            res_valid_o   <= 1'b0;
            res_row_o     <= '0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            i_q           <= i_d;
            k_q           <= k_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            arr_clear_o   <= clear_d;
            arr_en_o      <= en_d;
            op_rd_addr_o  <= addr_d;
            a_row_valid_o <= av_d;
            b_col_valid_o <= bv_d;
            res_valid_o   <= rv_d;
            res_row_o     <= row_d;
        end
    end
endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed bench for mac_array_sequencer: a 4x4 instance driven from a per-cycle
// expectation table plus hand sequences, and a 1x1 instance for the no-drain path.
module tb_mac_array_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] k_len = 8'd0;
    logic       abort = 1'b0;
    logic       res_ready = 1'b1;

    logic       busy, done, clr, en, rv;
    logic [7:0] addr;
    logic [3:0] av, bv;
    logic [1:0] row;

    logic       busy1, done1, clr1, en1, rv1;
    logic [7:0] addr1;
    logic [0:0] av1, bv1, row1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_array_sequencer #(.ROWS(4), .COLS(4), .K_WIDTH(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_len_i(k_len),
        .abort_i(abort), .res_ready_i(res_ready),
        .busy_o(busy), .done_o(done), .arr_clear_o(clr), .arr_en_o(en),
        .op_rd_addr_o(addr), .a_row_valid_o(av), .b_col_valid_o(bv),
        .res_valid_o(rv), .res_row_o(row)
    );

    mac_array_sequencer #(.ROWS(1), .COLS(1), .K_WIDTH(8)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .k_len_i(k_len),
        .abort_i(abort), .res_ready_i(res_ready),
        .busy_o(busy1), .done_o(done1), .arr_clear_o(clr1), .arr_en_o(en1),
        .op_rd_addr_o(addr1), .a_row_valid_o(av1), .b_col_valid_o(bv1),
        .res_valid_o(rv1), .res_row_o(row1)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       clr;
        logic       en;
        logic [7:0] addr;
        logic [3:0] av;
        logic [3:0] bv;
        logic       rv;
        logic [1:0] row;
    } vec_t;

    vec_t tbl4[16];
    vec_t tbl1[5];

    function automatic vec_t mk(logic b, logic d, logic c, logic e, logic [7:0] a,
                                logic [3:0] va, logic [3:0] vb, logic r, logic [1:0] rr);
        vec_t v;
        v = '{b, d, c, e, a, va, vb, r, rr};
        return v;
    endfunction

    function automatic vec_t act4();
        return '{busy, done, clr, en, addr, av, bv, rv, row};
    endfunction

    function automatic vec_t act1();
        return '{busy1, done1, clr1, en1, addr1, {3'b0, av1}, {3'b0, bv1}, rv1, {1'b0, row1}};
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] k);
        start = 1'b1;
        k_len = k;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_idle(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk(name, c, act4(), 32'd0);
        end
    endtask

    task automatic run_nominal(input string tag, input bit mid_start);
        pulse_start(8'd3);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk(tag, c, act4(), tbl4[c-1]);
            if (mid_start && c == 3) begin
                start = 1'b1;
                k_len = 8'd5;
            end else begin
                start = 1'b0;
            end
        end
        check_idle({tag, "_after"}, 4);
        $display("tile %s k=3 done, compared=%0d mismatched=%0d", tag, n_cmp, n_err);
    endtask

    initial begin
        // Expected outputs per cycle for 4x4, k_len=3 (S=9): clear, feed t=0..2, drain t=3..8, read, done, idle.
        tbl4[0]  = mk(1, 0, 1, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
        tbl4[1]  = mk(1, 0, 0, 1, 8'd0, 4'h1, 4'h1, 0, 2'd0);
        tbl4[2]  = mk(1, 0, 0, 1, 8'd1, 4'h3, 4'h3, 0, 2'd0);
        tbl4[3]  = mk(1, 0, 0, 1, 8'd2, 4'h7, 4'h7, 0, 2'd0);
        tbl4[4]  = mk(1, 0, 0, 1, 8'd2, 4'hE, 4'hE, 0, 2'd0);
        tbl4[5]  = mk(1, 0, 0, 1, 8'd2, 4'hC, 4'hC, 0, 2'd0);
        tbl4[6]  = mk(1, 0, 0, 1, 8'd2, 4'h8, 4'h8, 0, 2'd0);
        tbl4[7]  = mk(1, 0, 0, 1, 8'd2, 4'h0, 4'h0, 0, 2'd0);
        tbl4[8]  = mk(1, 0, 0, 1, 8'd2, 4'h0, 4'h0, 0, 2'd0);
        tbl4[9]  = mk(1, 0, 0, 1, 8'd2, 4'h0, 4'h0, 0, 2'd0);
        tbl4[10] = mk(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 1, 2'd0);
        tbl4[11] = mk(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 1, 2'd1);
        tbl4[12] = mk(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 1, 2'd2);
        tbl4[13] = mk(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 1, 2'd3);
        tbl4[14] = mk(1, 1, 0, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
        tbl4[15] = mk(0, 0, 0, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
        // 1x1, k_len=1 (S=1): no drain.
        tbl1[0] = mk(1, 0, 1, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
        tbl1[1] = mk(1, 0, 0, 1, 8'd0, 4'h1, 4'h1, 0, 2'd0);
        tbl1[2] = mk(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 1, 2'd0);
        tbl1[3] = mk(1, 1, 0, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
        tbl1[4] = mk(0, 0, 0, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);

        repeat (3) @(negedge clk);
        chk("reset4", 0, act4(), 32'd0);
        chk("reset1", 0, act1(), 32'd0);
        rst_n = 1'b1;
        check_idle("post_reset_idle", 3);

        run_nominal("nominal", 1'b0);

        // k_len=0 start is ignored.
        @(negedge clk);
        pulse_start(8'd0);
        check_idle("k0_ignored", 4);
        $display("tile k=0 ignored, compared=%0d mismatched=%0d", n_cmp, n_err);

        // start pulsed mid-FEED must not disturb or queue anything.
        @(negedge clk);
        run_nominal("mid_start", 1'b1);

        // Result stall: res_ready low for three edges while row 1 is presented.
        @(negedge clk);
        pulse_start(8'd3);
        for (int c = 1; c <= 19; c++) begin
            logic [4:0] exp_s;
            @(negedge clk);
            if (c < 11)       exp_s = {1'b1, 1'b0, 1'b0, 2'd0};
            else if (c == 11) exp_s = {1'b1, 1'b0, 1'b1, 2'd0};
            else if (c <= 15) exp_s = {1'b1, 1'b0, 1'b1, 2'd1};
            else if (c <= 17) exp_s = {1'b1, 1'b0, 1'b1, 2'(c - 14)};
            else if (c == 18) exp_s = {1'b1, 1'b1, 1'b0, 2'd0};
            else              exp_s = 5'd0;
            if (c >= 10) chk("stall", c, {busy, done, rv, row}, exp_s);
            res_ready = (c < 12) || (c > 14);
        end
        res_ready = 1'b1;
        $display("tile stall done, compared=%0d mismatched=%0d", n_cmp, n_err);

        // Abort at FEED t=2 (cycle 4).
        @(negedge clk);
        pulse_start(8'd3);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("abort_pre", c, act4(), tbl4[c-1]);
        end
        abort = 1'b1;
        @(negedge clk);
        chk("abort_idle", 5, act4(), 32'd0);
        abort = 1'b0;
        check_idle("abort_no_done", 3);
        $display("tile abort done, compared=%0d mismatched=%0d", n_cmp, n_err);
        run_nominal("after_abort", 1'b0);

        // Asynchronous reset while in READ.
        @(negedge clk);
        pulse_start(8'd3);
        for (int c = 1; c <= 12; c++) @(negedge clk);
        chk("pre_rst_read", 12, {rv, row}, {1'b1, 2'd1});
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 12, act4(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("rst_release_idle", 4);
        $display("tile reset-in-read done, compared=%0d mismatched=%0d", n_cmp, n_err);

        // 1x1 array, k_len=1.
        start1 = 1'b1;
        k_len  = 8'd1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("one_by_one", c, act1(), tbl1[c-1]);
        end
        $display("tile 1x1 done, compared=%0d mismatched=%0d", n_cmp, n_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
